lp_rply_buf: RTL and testbench

Loop replay buffer on the receiving end of the loop-detection unit's dispatch interface. It captures the 4-wide instruction bundles of a loop body that the detector flags with loop-start/valid-slot signals. Once the detector stalls fetch, it replays the captured body to the decoder, one iteration after another, until the detector signals unroll completion or a misprediction flushes it. Outside loops it is a registered pass-through between IF and decode.

---
 rtl/lp_rply_buf.sv | 187 ++++++++++++++++++
 tb/tb_lp_rply_buf.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lp_rply_buf.sv
// Loop replay buffer: registered IF->decode pass-through that captures a flagged
// loop body and replays it bundle by bundle until unroll finishes or a flush.
module lp_rply_buf #(
   parameter int DEPTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [63:0]             inst_in,
   input  logic [63:0]             pc_in,
   input  logic                    loop_strt_in,
   input  logic [3:0]              inst_valid_in,
   input  logic                    stll_ftch_in,
   input  logic                    fnsh_unrll_in,
   input  logic                    mis_pred_in,
   input  logic                    dec_rdy_in,
   output logic [63:0]             inst_out,
   output logic [63:0]             pc_out,
   output logic [3:0]              inst_valid_out,
   output logic                    rply_actv_out,
   output logic                    buf_full_out,
   output logic [$clog2(DEPTH):0]  lp_len_out,
   output logic [6:0]              iter_cnt_out,
   output logic [1:0]              state_dbg
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CAPT = 2'd1;
   localparam logic [1:0] S_RPLY = 2'd2;

   logic [1:0]    state;
   logic [LW-1:0] len;
   logic [LW-1:0] rd_ptr;
   logic          fin_pend;
   logic          full;
   logic          rply_loaded;
   logic          last_q;
   logic [6:0]    iter;
   logic [31:0]   mem [DEPTH];

   logic [2:0]    n_slots;
   logic          cap_en;
   logic [LW:0]   tot;
   logic          ovf;
   logic [LW-1:0] len_nxt;
   logic [LW-1:0] rem;
   logic [2:0]    k;
   logic [LW-1:0] rd_sum;
   logic          wrap;
   logic [63:0]   rb_inst;
   logic [63:0]   rb_pc;
   logic [3:0]    rb_mask;

   always_comb begin
      n_slots = 3'd0;
      case (inst_valid_in)
         4'b1000: n_slots = 3'd1;
         4'b1100: n_slots = 3'd2;
         4'b1110: n_slots = 3'd3;
         4'b1111: n_slots = 3'd4;
         default: n_slots = 3'd0;
      endcase
   end

   assign cap_en  = !mis_pred_in && ((state == S_IDLE && loop_strt_in) || state == S_CAPT);
   assign tot     = {1'b0, len} + {{(LW-2){1'b0}}, n_slots};
   assign ovf     = tot > {1'b0, LW'(DEPTH)};
   assign len_nxt = ovf ? LW'(DEPTH) : tot[LW-1:0];

   // Replay bundles are clipped at L so an iteration never spills into the next.
   assign rem    = len - rd_ptr;
   assign k      = (rem > LW'(4)) ? 3'd4 : rem[2:0];
   assign rd_sum = rd_ptr + {{(LW-3){1'b0}}, k};
   assign wrap   = rd_sum == len;

   always_comb begin
      rb_inst = '0;
      rb_pc   = '0;
      rb_mask = '0;
      for (int s = 0; s < 4; s++) begin
         if (3'(s) < k) begin
            rb_inst[63-16*s -: 16] = mem[PW'(rd_ptr + LW'(s))][31:16];
            rb_pc[63-16*s -: 16]   = mem[PW'(rd_ptr + LW'(s))][15:0];
            rb_mask[3-s]           = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap_en && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (3'(i) < n_slots && (len + LW'(i)) < LW'(DEPTH))
               mem[PW'(len + LW'(i))] <= {inst_in[63-16*i -: 16], pc_in[63-16*i -: 16]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || mis_pred_in) begin
         state          <= S_IDLE;
         inst_out       <= '0;
         pc_out         <= '0;
         inst_valid_out <= '0;
         len            <= '0;
         rd_ptr         <= '0;
         fin_pend       <= 1'b0;
         full           <= 1'b0;
         rply_loaded    <= 1'b0;
         last_q         <= 1'b0;
         if (rst) iter <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               inst_out       <= inst_in;
               pc_out         <= pc_in;
               inst_valid_out <= inst_valid_in;
               if (loop_strt_in) begin
                  state <= S_CAPT;
                  iter  <= '0;
                  len   <= len_nxt;
                  full  <= ovf;
               end
            end
            S_CAPT: begin
               inst_out       <= inst_in;
               pc_out         <= pc_in;
               inst_valid_out <= inst_valid_in;
               len            <= len_nxt;
               if (ovf) full <= 1'b1;
               if (stll_ftch_in) begin
                  if (len_nxt == '0) begin
                     state <= S_IDLE;
                     len   <= '0;
                     full  <= 1'b0;
                  end else begin
                     state       <= S_RPLY;
                     rd_ptr      <= '0;
                     rply_loaded <= 1'b0;
                     last_q      <= 1'b0;
                     fin_pend    <= 1'b0;
                  end
               end
            end
            S_RPLY: begin
               if (fnsh_unrll_in) fin_pend <= 1'b1;
               if (last_q) begin
                  if (dec_rdy_in) begin
                     state          <= S_IDLE;
                     inst_out       <= '0;
                     pc_out         <= '0;
                     inst_valid_out <= '0;
                     len            <= '0;
                     rd_ptr         <= '0;
                     fin_pend       <= 1'b0;
                     full           <= 1'b0;
                     rply_loaded    <= 1'b0;
                     last_q         <= 1'b0;
                  end
               end else if (!rply_loaded || dec_rdy_in) begin
                  // The pass-through bundle left over from capture counts as empty.
                  inst_out       <= rb_inst;
                  pc_out         <= rb_pc;
                  inst_valid_out <= rb_mask;
                  rply_loaded    <= 1'b1;
                  if (wrap) begin
                     rd_ptr <= '0;
                     if (iter != 7'h7f) iter <= iter + 7'd1;
                     if (fin_pend || fnsh_unrll_in) last_q <= 1'b1;
                  end else begin
                     rd_ptr <= rd_sum;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign rply_actv_out = state == S_RPLY;
   assign buf_full_out  = full;
   assign lp_len_out    = len;
   assign iter_cnt_out  = iter;
   assign state_dbg     = state;

endmodule

// File: tb/tb_lp_rply_buf.sv
// Bench for lp_rply_buf: scoreboard of expected decode-side bundles plus
// directed checks on length, iteration count, overflow, flush and reset.
module tb_lp_rply_buf;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] inst_in, pc_in;
   logic        loop_strt_in, stll_ftch_in, fnsh_unrll_in, mis_pred_in, dec_rdy_in;
   logic [3:0]  inst_valid_in;
   logic [63:0] inst_out, pc_out;
   logic [3:0]  inst_valid_out;
   logic        rply_actv_out, buf_full_out;
   logic [6:0]  lp_len_out, iter_cnt_out;
   logic [1:0]  state_dbg;

   always #5 clk = ~clk;

   lp_rply_buf #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .inst_in(inst_in), .pc_in(pc_in),
      .loop_strt_in(loop_strt_in), .inst_valid_in(inst_valid_in),
      .stll_ftch_in(stll_ftch_in), .fnsh_unrll_in(fnsh_unrll_in),
      .mis_pred_in(mis_pred_in), .dec_rdy_in(dec_rdy_in),
      .inst_out(inst_out), .pc_out(pc_out), .inst_valid_out(inst_valid_out),
      .rply_actv_out(rply_actv_out), .buf_full_out(buf_full_out),
      .lp_len_out(lp_len_out), .iter_cnt_out(iter_cnt_out), .state_dbg(state_dbg)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [131:0] exp_q[$];
   logic [15:0]  cap_inst[$];
   logic [15:0]  cap_pc[$];
   int           rp;
   logic [3:0]   mask_tbl [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] slot_mask(input logic [3:0] m);
      logic [63:0] r;
      r = '0;
      for (int s = 0; s < 4; s++) if (m[3-s]) r[63-16*s -: 16] = 16'hffff;
      return r;
   endfunction

   function automatic int lead_ones(input logic [3:0] m);
      case (m)
         4'b1000: return 1;
         4'b1100: return 2;
         4'b1110: return 3;
         4'b1111: return 4;
         default: return 0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] inst, input logic [63:0] pc, input logic [3:0] mask,
                        input logic strt, input logic stll, input logic cap);
      inst_in       = inst;
      pc_in         = pc;
      inst_valid_in = mask;
      loop_strt_in  = strt;
      stll_ftch_in  = stll;
      if (mask != 4'b0000 && !rply_actv_out) exp_q.push_back({inst, pc, mask});
      if (cap) begin
         for (int i = 0; i < lead_ones(mask); i++) begin
            if (cap_inst.size() < DEPTH) begin
               cap_inst.push_back(inst[63-16*i -: 16]);
               cap_pc.push_back(pc[63-16*i -: 16]);
            end
         end
      end
   endtask

   task automatic push_rply(input int nb);
      int L, k;
      logic [63:0] bi, bp;
      logic [3:0]  bm;
      L = cap_inst.size();
      for (int b = 0; b < nb; b++) begin
         bi = '0; bp = '0; bm = '0;
         k = (L - rp > 4) ? 4 : L - rp;
         for (int s = 0; s < k; s++) begin
            bi[63-16*s -: 16] = cap_inst[rp+s];
            bp[63-16*s -: 16] = cap_pc[rp+s];
            bm[3-s] = 1'b1;
         end
         exp_q.push_back({bi, bp, bm});
         rp = rp + k;
         if (rp == L) rp = 0;
      end
   endtask

   task automatic new_capture();
      cap_inst.delete();
      cap_pc.delete();
      rp = 0;
   endtask

   task automatic idle_inputs();
      drive({$urandom, $urandom}, {$urandom, $urandom}, 4'b0000, 1'b0, 1'b0, 1'b0);
   endtask

   // A bundle is transferred whenever the output is valid and decode is ready.
   logic [131:0] mon_e;
   logic [63:0]  mon_m;
   always @(negedge clk) begin
      if (!rst && inst_valid_out != 4'b0000 && dec_rdy_in) begin
         if (exp_q.size() == 0) begin
            check("sb_extra", 64'(inst_valid_out), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            mon_m = slot_mask(mon_e[3:0]);
            check("sb_mask", 64'(inst_valid_out), 64'(mon_e[3:0]));
            check("sb_inst", inst_out & mon_m, mon_e[131:68] & mon_m);
            check("sb_pc", pc_out & mon_m, mon_e[67:4] & mon_m);
         end
      end
   end

   initial begin
      rst = 1'b1;
      inst_in = '0; pc_in = '0; inst_valid_in = '0;
      loop_strt_in = 1'b0; stll_ftch_in = 1'b0; fnsh_unrll_in = 1'b0;
      mis_pred_in = 1'b0; dec_rdy_in = 1'b1;
      tick(); tick();
      check("rst_inst", inst_out, 64'd0);
      check("rst_pc", pc_out, 64'd0);
      check("rst_valid", 64'(inst_valid_out), 64'd0);
      check("rst_actv", 64'(rply_actv_out), 64'd0);
      check("rst_full", 64'(buf_full_out), 64'd0);
      check("rst_len", 64'(lp_len_out), 64'd0);
      check("rst_iter", 64'(iter_cnt_out), 64'd0);
      rst = 1'b0;

      // pass-through
      drive(64'h0001_0002_0003_0004, {$urandom, $urandom}, 4'b1111, 1'b0, 1'b0, 1'b0);
      tick();
      check("pt_inst", inst_out, 64'h0001_0002_0003_0004);
      check("pt_valid", 64'(inst_valid_out), 64'hf);
      for (int i = 0; i < 6; i++) begin
         drive({$urandom, $urandom}, {$urandom, $urandom}, mask_tbl[$urandom_range(0, 3)],
               1'b0, 1'b0, 1'b0);
         tick();
      end
      idle_inputs();
      tick();
      check("pt_idle_valid", 64'(inst_valid_out), 64'd0);

      // capture 6 instructions and replay three iterations
      new_capture();
      drive({$urandom, $urandom}, 64'h0010_0011_0012_0013, 4'b1111, 1'b1, 1'b0, 1'b1);
      tick();
      check("cap_len4", 64'(lp_len_out), 64'd4);
      check("cap_state", 64'(state_dbg), 64'd1);
      drive({$urandom, $urandom}, 64'h0014_0015_0000_0000, 4'b1100, 1'b0, 1'b1, 1'b1);
      push_rply(6);
      tick();
      check("rply_actv", 64'(rply_actv_out), 64'd1);
      check("cap_len6", 64'(lp_len_out), 64'd6);
      idle_inputs();
      tick();
      tick();
      check("iter1", 64'(iter_cnt_out), 64'd1);
      tick();
      dec_rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_mask", 64'(inst_valid_out), 64'(exp_q[0][3:0]));
         check("bp_inst", inst_out & slot_mask(exp_q[0][3:0]), exp_q[0][131:68]);
         check("bp_pc", pc_out & slot_mask(exp_q[0][3:0]), exp_q[0][67:4]);
      end
      dec_rdy_in = 1'b1;
      tick();
      check("iter2", 64'(iter_cnt_out), 64'd2);
      tick();
      fnsh_unrll_in = 1'b1;
      tick();
      fnsh_unrll_in = 1'b0;
      check("iter3", 64'(iter_cnt_out), 64'd3);
      check("last_actv", 64'(rply_actv_out), 64'd1);
      check("last_mask", 64'(inst_valid_out), 64'hc);
      tick();
      check("fin_actv", 64'(rply_actv_out), 64'd0);
      check("fin_valid", 64'(inst_valid_out), 64'd0);
      check("fin_iter", 64'(iter_cnt_out), 64'd3);
      check("fin_len", 64'(lp_len_out), 64'd0);
      check("fin_drain", 64'(exp_q.size()), 64'd0);

      // overflow: 70 instructions into a 64-entry buffer, then flush mid-replay
      new_capture();
      drive({$urandom, $urandom}, {$urandom, $urandom}, 4'b1111, 1'b1, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 15; i++) begin
         drive({$urandom, $urandom}, {$urandom, $urandom}, 4'b1111, 1'b0, 1'b0, 1'b1);
         tick();
      end
      check("at_depth_len", 64'(lp_len_out), 64'd64);
      check("at_depth_full", 64'(buf_full_out), 64'd0);
      drive({$urandom, $urandom}, {$urandom, $urandom}, 4'b1111, 1'b0, 1'b0, 1'b1);
      tick();
      check("ovf_full", 64'(buf_full_out), 64'd1);
      drive({$urandom, $urandom}, {$urandom, $urandom}, 4'b1100, 1'b0, 1'b1, 1'b1);
      push_rply(3);
      tick();
      check("ovf_len", 64'(lp_len_out), 64'd64);
      check("ovf_full_rply", 64'(buf_full_out), 64'd1);
      check("ovf_actv", 64'(rply_actv_out), 64'd1);
      idle_inputs();
      tick(); tick(); tick();
      mis_pred_in = 1'b1;
      tick();
      mis_pred_in = 1'b0;
      check("flush_valid", 64'(inst_valid_out), 64'd0);
      check("flush_actv", 64'(rply_actv_out), 64'd0);
      check("flush_full", 64'(buf_full_out), 64'd0);
      check("flush_len", 64'(lp_len_out), 64'd0);
      check("flush_iter", 64'(iter_cnt_out), 64'd0);

      // 4-entry body, then reset mid-replay
      new_capture();
      drive({$urandom, $urandom}, {$urandom, $urandom}, 4'b1110, 1'b1, 1'b0, 1'b1);
      tick();
      drive({$urandom, $urandom}, {$urandom, $urandom}, 4'b1000, 1'b0, 1'b1, 1'b1);
      push_rply(1);
      tick();
      check("l4_len", 64'(lp_len_out), 64'd4);
      idle_inputs();
      tick();
      check("l4_iter", 64'(iter_cnt_out), 64'd1);
      check("l4_mask", 64'(inst_valid_out), 64'hf);
      tick();
      rst = 1'b1;
      tick();
      check("mrst_inst", inst_out, 64'd0);
      check("mrst_pc", pc_out, 64'd0);
      check("mrst_valid", 64'(inst_valid_out), 64'd0);
      check("mrst_actv", 64'(rply_actv_out), 64'd0);
      check("mrst_len", 64'(lp_len_out), 64'd0);
      check("mrst_iter", 64'(iter_cnt_out), 64'd0);
      check("mrst_state", 64'(state_dbg), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_actv", 64'(rply_actv_out), 64'd0);
      check("post_rst_valid", 64'(inst_valid_out), 64'd0);
      check("sb_drain", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
